// File: rtl/axis_packet_checker.sv
// Loopback test-traffic generator: sends one deterministic AXI-Stream packet per
// start request, collects the echoed response and reports mismatches/framing errors.
module axis_packet_checker #(
  parameter int          C_AXIS_TDATA_WIDTH = 32,
  parameter int          C_PACKET_WORDS     = 8,
  parameter int          C_START_COUNT      = 32,
  parameter int          C_TIMEOUT          = 1024,
  parameter logic [31:0] C_SEED             = 32'h0000_1000
) (
  input  logic                              axis_aclk,
  input  logic                              axis_areset,
  input  logic                              start,
  output logic                              m_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [7:0]                        err_count,
  output logic [15:0]                       pkt_count,
  output logic [2:0]                        dbg_state
);

  localparam int W     = C_AXIS_TDATA_WIDTH;
  localparam int IDX_W = (C_PACKET_WORDS > 2) ? $clog2(C_PACKET_WORDS) : 1;
  localparam int SC_W  = $clog2(C_START_COUNT + 2);
  localparam int TO_W  = $clog2(C_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(C_PACKET_WORDS - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(C_PACKET_WORDS - 2);

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SEND    = 3'd2,
    ST_RECV    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_REPORT  = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   beat_idx;
  logic [SC_W-1:0]    start_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               last_idx;
  logic               s_fire;
  logic               word_err;
  logic               to_hit;
  logic [1:0]         err_inc;
  logic [8:0]         err_sum;
  logic [7:0]         err_next;
  logic               unused_tstrb;

  // Word i of packet pc; both the sender and the response compare use this.
  function automatic logic [W-1:0] pattern(input logic [15:0] pc, input logic [IDX_W-1:0] idx);
    return W'(C_SEED) + W'(pc) * W'(C_PACKET_WORDS) + W'(idx);
  endfunction

  // Handshakes: a beat moves on a rising edge where tvalid && tready are both high;
  // once raised, m_axis_tvalid/tdata/tlast hold until that edge.
  assign m_axis_tstrb = '1;
  assign unused_tstrb = ^s_axis_tstrb;
  assign dbg_state    = state;
  assign last_idx     = (beat_idx == LAST_IDX);
  assign s_fire       = s_axis_tvalid && s_axis_tready;
  assign word_err     = (s_axis_tdata != pattern(pkt_count, beat_idx));
  assign to_hit       = !s_fire && (int'(to_cnt) >= C_TIMEOUT - 1);

  // Data error and framing error can land on the same beat, so up to +2 at once.
  always_comb begin
    err_inc  = 2'(word_err) + 2'(s_axis_tlast && !last_idx) + 2'(!s_axis_tlast && last_idx);
    err_sum  = {1'b0, err_count} + 9'(err_inc);
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) state <= ST_STARTUP;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_STARTUP: if (int'(start_cnt) >= C_START_COUNT - 1) state_next = ST_IDLE;
      ST_IDLE:    if (start) state_next = ST_SEND;
      ST_SEND:    if (m_axis_tvalid && m_axis_tready && last_idx) state_next = ST_RECV;
      ST_RECV: begin
        if (s_fire) begin
          if (s_axis_tlast)  state_next = ST_REPORT;
          else if (last_idx) state_next = ST_DRAIN;
        end else if (to_hit) begin
          state_next = ST_REPORT;
        end
      end
      ST_DRAIN: begin
        if (s_fire && s_axis_tlast) state_next = ST_REPORT;
        else if (to_hit)            state_next = ST_REPORT;
      end
      ST_REPORT:  state_next = ST_IDLE;
      default:    state_next = ST_STARTUP;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= 8'd0;
      pkt_count     <= 16'd0;
      beat_idx      <= '0;
      start_cnt     <= '0;
      to_cnt        <= '0;
    end else begin
      busy          <= (state_next != ST_IDLE) && (state_next != ST_STARTUP);
      s_axis_tready <= (state_next == ST_RECV) || (state_next == ST_DRAIN);
      done          <= (state == ST_REPORT);
      case (state)
        ST_STARTUP: start_cnt <= start_cnt + SC_W'(1);
        ST_IDLE: begin
          if (start) begin
            err_count <= 8'd0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            beat_idx  <= '0;
            to_cnt    <= '0;
          end
        end
        ST_SEND: begin
          // tvalid is low only in the first SEND cycle; that is where beat 0 is loaded.
          if (!m_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pattern(pkt_count, '0);
            m_axis_tlast  <= 1'b0;
          end else if (m_axis_tready) begin
            if (last_idx) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
              beat_idx      <= '0;
            end else begin
              beat_idx     <= beat_idx + IDX_W'(1);
              m_axis_tdata <= m_axis_tdata + W'(1);
              m_axis_tlast <= (beat_idx == PENULT_IDX);
            end
          end
        end
        ST_RECV: begin
          if (s_fire) begin
            to_cnt    <= '0;
            err_count <= err_next;
            if (!last_idx) beat_idx <= beat_idx + IDX_W'(1);
          end else if (to_hit) begin
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_DRAIN: begin
          if (s_fire)      to_cnt  <= '0;
          else if (to_hit) timeout <= 1'b1;
          else             to_cnt  <= to_cnt + TO_W'(1);
        end
        ST_REPORT: begin
          pass      <= (err_count == 8'd0) && !timeout;
          pkt_count <= pkt_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_checker.sv
// Directed bench for axis_packet_checker: plays the echo responder and checks
// outgoing words, framing/timeout results, handshake stability and reset behaviour.
module tb_axis_packet_checker;

  logic        axis_aclk = 1'b0;
  logic        axis_areset;
  logic        start;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tstrb;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_count;
  logic [15:0] pkt_count;
  logic [2:0]  dbg_state;

  axis_packet_checker dut (
    .axis_aclk    (axis_aclk),
    .axis_areset  (axis_areset),
    .start        (start),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tstrb (s_axis_tstrb),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .err_count    (err_count),
    .pkt_count    (pkt_count),
    .dbg_state    (dbg_state)
  );

  // clock / cycle counter
  always #5 axis_aclk = ~axis_aclk;
  int cyc = 0;
  always @(posedge axis_aclk) cyc <= cyc + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] resp_data [16];
  int          resp_n;
  int          resp_last_at;
  int          n_cmp = 0;
  int          n_err = 0;
  int          t_start, last_acc_cyc, done_cyc, lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    t_start = cyc;
  endtask

  // Response: echo of packet p for beats < 8, junk beyond; tlast at index last_at.
  task automatic fill_resp(input int p, input int n, input int last_at);
    for (int k = 0; k < 16; k++)
      resp_data[k] = (k < 8) ? 32'h1000 + 32'(p * 8 + k) : 32'hDEAD_0000 + 32'(k);
    resp_n       = n;
    resp_last_at = last_at;
  endtask

  task automatic send_phase(input int p, input bit bp, input int stop_at);
    int          i;
    int          guard;
    bit          stalled;
    logic [31:0] held_data;
    logic        held_last;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h1000 + 32'(p * 8 + k));
    i = 0; guard = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
    while (i < 8 && guard < 400) begin
      if (i == stop_at && m_axis_tvalid) break;
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check_eq("hold_data", m_axis_tdata, held_data);
        check_eq("hold_last", 32'(m_axis_tlast), 32'(held_last));
        check_eq("hold_valid", 32'(m_axis_tvalid), 32'd1);
      end
      stalled = 1'b0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          check_eq("tx_data", m_axis_tdata, exp_q.pop_front());
          check_eq("tx_last", 32'(m_axis_tlast), 32'(i == 7));
          check_eq("rx_rdy_in_tx", 32'(s_axis_tready), 32'd0);
          i++;
        end else begin
          stalled   = 1'b1;
          held_data = m_axis_tdata;
          held_last = m_axis_tlast;
        end
      end
      cycle();
      guard++;
    end
    m_axis_tready = 1'b0;
    if (i < 8 && i != stop_at) check_eq("tx_beats", 32'(i), 32'd8);
  endtask

  task automatic recv_phase(input bit bp);
    int k;
    int guard;
    k = 0; guard = 0;
    while (k < resp_n && guard < 400) begin
      s_axis_tvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata  = resp_data[k];
      s_axis_tlast  = (k == resp_last_at);
      if (s_axis_tvalid && s_axis_tready) k++;
      cycle();
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    last_acc_cyc  = cyc;
    if (k < resp_n) check_eq("rx_beats", 32'(k), 32'(resp_n));
  endtask

  task automatic wait_done(output int lat_o);
    int guard;
    guard = 0;
    while (!done && guard < 2000) begin
      cycle();
      guard++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
    done_cyc = cyc;
    lat_o    = cyc - last_acc_cyc;
  endtask

  task automatic run_check(input string name, input int p, input bit bp,
                           input logic [7:0] exp_err, input bit exp_pass, input bit exp_to,
                           input logic [15:0] exp_pkt, input int exp_lat);
    int l;
    pulse_start();
    check_eq({name, "_busy"}, 32'(busy), 32'd1);
    send_phase(p, bp, 8);
    recv_phase(bp);
    wait_done(l);
    lat = l;
    check_eq({name, "_pass"}, 32'(pass), 32'(exp_pass));
    check_eq({name, "_err"}, 32'(err_count), 32'(exp_err));
    check_eq({name, "_timeout"}, 32'(timeout), 32'(exp_to));
    check_eq({name, "_pkt"}, 32'(pkt_count), 32'(exp_pkt));
    if (exp_lat >= 0) check_eq({name, "_lat"}, 32'(l), 32'(exp_lat));
    cycle();
    check_eq({name, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({name, "_idle"}, 32'(busy), 32'd0);
    check_eq({name, "_pass_held"}, 32'(pass), 32'(exp_pass));
  endtask

  initial begin
    axis_areset = 1'b1; start = 1'b0; m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tstrb = 4'hF;
    repeat (3) cycle();
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", m_axis_tdata, 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_s_rdy", 32'(s_axis_tready), 32'd0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_pass_to", {30'd0, pass, timeout}, 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_pkt", 32'(pkt_count), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("tstrb", 32'(m_axis_tstrb), 32'hF);

    // start during STARTUP must be ignored; IDLE reached exactly 32 cycles after release
    axis_areset = 1'b0;
    repeat (4) cycle();
    pulse_start();
    cycle();
    check_eq("startup_ignore_busy", 32'(busy), 32'd0);
    check_eq("startup_ignore_tvalid", 32'(m_axis_tvalid), 32'd0);
    repeat (25) cycle();
    check_eq("startup_still", 32'(dbg_state), 32'd0);
    cycle();
    check_eq("startup_to_idle", 32'(dbg_state), 32'd1);

    // ideal echo, 0x1000..0x1007; start-to-done = 18 cycles
    fill_resp(0, 8, 7);
    run_check("ideal", 0, 1'b0, 8'd0, 1'b1, 1'b0, 16'd1, 1);
    check_eq("ideal_start_to_done", 32'(done_cyc - t_start), 32'd18);

    fill_resp(1, 8, 7);
    run_check("second", 1, 1'b0, 8'd0, 1'b1, 1'b0, 16'd2, 1);

    fill_resp(2, 8, 7);
    resp_data[3] = 32'h1013 ^ 32'h1;
    run_check("corrupt", 2, 1'b0, 8'd1, 1'b0, 1'b0, 16'd3, 1);

    fill_resp(3, 8, 7);
    run_check("backpressure", 3, 1'b1, 8'd0, 1'b1, 1'b0, 16'd4, -1);

    fill_resp(4, 6, 5);
    run_check("short", 4, 1'b0, 8'd1, 1'b0, 1'b0, 16'd5, 1);

    fill_resp(5, 10, 9);
    run_check("long", 5, 1'b0, 8'd1, 1'b0, 1'b0, 16'd6, 1);

    // responder stops after 4 beats: abort after ~1024 idle cycles
    fill_resp(6, 4, -1);
    run_check("timeout", 6, 1'b0, 8'd0, 1'b0, 1'b1, 16'd7, -1);
    check_eq("timeout_window", 32'(lat >= 1024 && lat <= 1026), 32'd1);

    // reset while beat 2 is on the bus
    pulse_start();
    send_phase(7, 1'b0, 2);
    check_eq("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_eq("pre_rst_beat2", m_axis_tdata, 32'h103A);
    axis_areset = 1'b1;
    #1;
    check_eq("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("midrst_pkt", 32'(pkt_count), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    cycle();
    axis_areset = 1'b0;
    repeat (33) cycle();
    fill_resp(0, 8, 7);
    run_check("after_rst", 0, 1'b0, 8'd0, 1'b1, 1'b0, 16'd1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
